// File: rtl/letc_core_cache_nway.sv
// N-way set-associative, write-through, no-write-allocate cache between a pipeline stage and the AXI FSM.
// Round-robin replacement, store hit update, and fills squashed by a flush.
module letc_core_cache_nway #(
    parameter int unsigned PADDR_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH  = 6,
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned WAY_WIDTH    = 1,
    parameter int unsigned READ_ONLY    = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush_cache,
    // stage_limp (servicer)
    input  logic                   i_stage_valid,
    output logic                   o_stage_ready,
    input  logic                   i_stage_wen_nren,
    input  logic [1:0]             i_stage_size,
    input  logic [PADDR_WIDTH-1:0] i_stage_addr,
    input  logic [31:0]            i_stage_wdata,
    output logic [31:0]            o_stage_rdata,
    // axi_fsm_limp (requestor)
    output logic                   o_axi_valid,
    input  logic                   i_axi_ready,
    output logic                   o_axi_wen_nren,
    output logic [1:0]             o_axi_size,
    output logic [PADDR_WIDTH-1:0] o_axi_addr,
    output logic [31:0]            o_axi_wdata,
    input  logic [31:0]            i_axi_rdata
);
    localparam int unsigned SETS       = 2 ** INDEX_WIDTH;
    localparam int unsigned LINE_WORDS = 2 ** OFFSET_WIDTH;
    localparam int unsigned WAYS       = 2 ** WAY_WIDTH;
    localparam int unsigned IDX_LO     = OFFSET_WIDTH + 2;
    localparam int unsigned TAG_LO     = IDX_LO + INDEX_WIDTH;
    localparam int unsigned TAG_WIDTH  = PADDR_WIDTH - TAG_LO;
    localparam int unsigned WAY_IDX_W  = (WAY_WIDTH == 0) ? 1 : WAY_WIDTH;
    localparam int unsigned DADDR_W    = INDEX_WIDTH + OFFSET_WIDTH;
    localparam int unsigned DEPTH      = SETS * LINE_WORDS;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    if (PADDR_WIDTH <= TAG_LO) begin : g_bad_tag
        $error("letc_core_cache_nway: TAG_WIDTH must be > 0");
    end

    typedef enum logic [1:0] {IDLE, FILL, TAG, STORE} state_e;

    state_e                     r_state, w_state_nxt;
    logic [WAYS-1:0][SETS-1:0]  r_valid;
    logic [WAY_IDX_W-1:0]       r_rr_ptr;
    logic                       r_squash;
    logic [WAY_IDX_W-1:0]       r_victim;
    logic [TAG_WIDTH-1:0]       r_line_tag;
    logic [INDEX_WIDTH-1:0]     r_line_index;
    logic [OFFSET_WIDTH-1:0]    r_beat;

    logic [31:0]                r_data [WAYS][DEPTH];
    logic [TAG_WIDTH-1:0]       r_tag  [WAYS][SETS];

    logic [TAG_WIDTH-1:0]       w_tag;
    logic [INDEX_WIDTH-1:0]     w_index;
    logic [OFFSET_WIDTH-1:0]    w_woff;
    logic [1:0]                 w_boff;
    logic [DADDR_W-1:0]         w_daddr;
    logic [WAYS-1:0]            w_hit_vec;
    logic                       w_hit;
    logic [WAY_IDX_W-1:0]       w_hit_way;
    logic [31:0]                w_hit_word;
    logic [31:0]                w_shifted;
    logic [31:0]                w_rd_fmt;
    logic [WAY_IDX_W-1:0]       w_victim;
    logic                       w_found;
    logic [3:0]                 w_be;
    logic [31:0]                w_wdata_sh;
    logic                       w_fill_start, w_fill_we, w_tag_we, w_store_we;

    assign w_tag   = i_stage_addr[PADDR_WIDTH-1:TAG_LO];
    assign w_index = i_stage_addr[TAG_LO-1:IDX_LO];
    assign w_woff  = i_stage_addr[IDX_LO-1:2];
    assign w_boff  = i_stage_addr[1:0];
    assign w_daddr = {w_index, w_woff};

    // Tag lookup across all ways; the hit word is OR-merged since at most one way may match.
    always_comb begin
        w_hit_vec  = '0;
        w_hit_way  = '0;
        w_hit_word = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w][w_index] && (r_tag[w][w_index] == w_tag);
            if (w_hit_vec[w]) begin
                w_hit_word = w_hit_word | r_data[w][w_daddr];
                w_hit_way  = WAY_IDX_W'(w);
            end
        end
        w_hit = $onehot(w_hit_vec);
    end

    // Victim: lowest invalid way in the set, otherwise the round-robin pointer.
    always_comb begin
        w_victim = r_rr_ptr;
        w_found  = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!w_found && !r_valid[w][w_index]) begin
                w_victim = WAY_IDX_W'(w);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_shifted  = w_hit_word >> {w_boff, 3'b000};
        w_wdata_sh = i_stage_wdata << {w_boff, 3'b000};
        case (i_stage_size)
            SIZE_BYTE: begin
                w_rd_fmt = {24'h0, w_shifted[7:0]};
                w_be     = 4'b0001 << w_boff;
            end
            SIZE_HALF: begin
                w_rd_fmt = {16'h0, w_shifted[15:0]};
                w_be     = 4'b0011 << w_boff;
            end
            default: begin
                w_rd_fmt = w_shifted;
                w_be     = 4'b1111;
            end
        endcase
    end

    // Next state and both LIMP ports.
    always_comb begin
        w_state_nxt    = r_state;
        o_stage_ready  = 1'b0;
        o_stage_rdata  = '0;
        o_axi_valid    = 1'b0;
        o_axi_wen_nren = 1'b0;
        o_axi_size     = SIZE_WORD;
        o_axi_addr     = '0;
        o_axi_wdata    = '0;
        w_fill_start   = 1'b0;
        w_fill_we      = 1'b0;
        w_tag_we       = 1'b0;
        w_store_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_stage_valid) begin
                    if (i_stage_wen_nren) begin
                        if (READ_ONLY == 0) w_state_nxt = STORE;
                    end else if (w_hit) begin
                        o_stage_ready = 1'b1;
                        o_stage_rdata = w_rd_fmt;
                    end else begin
                        w_state_nxt  = FILL;
                        w_fill_start = 1'b1;
                    end
                end
            end
            FILL: begin
                o_axi_valid = 1'b1;
                o_axi_addr  = {r_line_tag, r_line_index, r_beat, 2'b00};
                if (i_axi_ready) begin
                    w_fill_we = 1'b1;
                    if (r_beat == '1) w_state_nxt = TAG;
                end
            end
            TAG: begin
                w_tag_we    = 1'b1;
                w_state_nxt = IDLE;
            end
            STORE: begin
                o_axi_valid    = 1'b1;
                o_axi_wen_nren = 1'b1;
                o_axi_size     = i_stage_size;
                o_axi_addr     = i_stage_addr;
                o_axi_wdata    = i_stage_wdata;
                if (i_axi_ready) begin
                    o_stage_ready = 1'b1;
                    w_store_we    = w_hit && (READ_ONLY == 0);
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Control state; a flush in TAG overrides the valid set because it is assigned last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_rr_ptr     <= '0;
            r_squash     <= 1'b0;
            r_victim     <= '0;
            r_line_tag   <= '0;
            r_line_index <= '0;
            r_beat       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fill_start) begin
                r_victim     <= w_victim;
                r_line_tag   <= w_tag;
                r_line_index <= w_index;
                r_beat       <= '0;
            end
            if (w_fill_we) r_beat <= r_beat + OFFSET_WIDTH'(1);
            if (w_tag_we) begin
                if (!r_squash) r_valid[r_victim][r_line_index] <= 1'b1;
                r_rr_ptr <= (WAY_WIDTH == 0) ? '0 : r_rr_ptr + WAY_IDX_W'(1);
                r_squash <= 1'b0;
            end
            if (i_flush_cache) begin
                r_valid <= '0;
                if (r_state == FILL) r_squash <= 1'b1;
            end
        end
    end

    // Data and tag arrays: combinational read, synchronous write, no reset.
    always_ff @(posedge i_clk) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (w_fill_we && r_victim == WAY_IDX_W'(w))
                r_data[w][{r_line_index, r_beat}] <= i_axi_rdata;
            if (w_store_we && w_hit_way == WAY_IDX_W'(w)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (w_be[b]) r_data[w][w_daddr][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
            if (w_tag_we && r_victim == WAY_IDX_W'(w))
                r_tag[w][r_line_index] <= r_line_tag;
        end
    end

    a_multi_hit: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(r_state == IDLE && i_stage_valid && ($countones(w_hit_vec) > 1)));

    a_ro_store: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !((READ_ONLY != 0) && i_stage_valid && i_stage_wen_nren));

endmodule

// File: tb/tb_letc_core_cache_nway.sv
// Directed bench for letc_core_cache_nway: a 2-way instance (d=0) and a direct-mapped instance (d=1)
// with a small AXI memory responder that accepts every other cycle.
module tb_letc_core_cache_nway;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk = 1'b0;
    logic [1:0]  rst_n, flush, s_valid, s_wen, s_ready, a_valid, a_wen;
    logic [1:0]  a_ready = 2'b00;
    logic [1:0]  s_size [2];
    logic [1:0]  a_size [2];
    logic [31:0] s_addr [2], s_wdata [2], s_rdata [2];
    logic [31:0] a_addr [2], a_wdata [2], a_rdata [2];

    logic [31:0] lg_addr  [2][64];
    logic [31:0] lg_wdata [2][64];
    logic [1:0]  lg_size  [2][64];
    logic        lg_wen   [2][64];
    int          lg_n [2] = '{0, 0};

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    letc_core_cache_nway #(.PADDR_WIDTH(32), .INDEX_WIDTH(2), .OFFSET_WIDTH(1), .WAY_WIDTH(1), .READ_ONLY(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_flush_cache(flush[0]),
        .i_stage_valid(s_valid[0]), .o_stage_ready(s_ready[0]), .i_stage_wen_nren(s_wen[0]),
        .i_stage_size(s_size[0]), .i_stage_addr(s_addr[0]), .i_stage_wdata(s_wdata[0]), .o_stage_rdata(s_rdata[0]),
        .o_axi_valid(a_valid[0]), .i_axi_ready(a_ready[0]), .o_axi_wen_nren(a_wen[0]),
        .o_axi_size(a_size[0]), .o_axi_addr(a_addr[0]), .o_axi_wdata(a_wdata[0]), .i_axi_rdata(a_rdata[0]));

    letc_core_cache_nway #(.PADDR_WIDTH(32), .INDEX_WIDTH(2), .OFFSET_WIDTH(1), .WAY_WIDTH(0), .READ_ONLY(0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_flush_cache(flush[1]),
        .i_stage_valid(s_valid[1]), .o_stage_ready(s_ready[1]), .i_stage_wen_nren(s_wen[1]),
        .i_stage_size(s_size[1]), .i_stage_addr(s_addr[1]), .i_stage_wdata(s_wdata[1]), .o_stage_rdata(s_rdata[1]),
        .o_axi_valid(a_valid[1]), .i_axi_ready(a_ready[1]), .o_axi_wen_nren(a_wen[1]),
        .o_axi_size(a_size[1]), .o_axi_addr(a_addr[1]), .o_axi_wdata(a_wdata[1]), .i_axi_rdata(a_rdata[1]));

    // Backing memory: one hand-picked word at 0x100, an address-derived pattern elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a[31:2] == 30'h40) return 32'hAABBCCDD;
        return 32'h1234_0000 | {16'h0, a[15:2], 2'b00};
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            a_ready[d] <= a_valid[d] && !a_ready[d];
            a_rdata[d] <= memf(a_addr[d]);
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (a_valid[d] && a_ready[d]) begin
                lg_addr[d][lg_n[d] % 64]  <= a_addr[d];
                lg_wdata[d][lg_n[d] % 64] <= a_wdata[d];
                lg_size[d][lg_n[d] % 64]  <= a_size[d];
                lg_wen[d][lg_n[d] % 64]   <= a_wen[d];
                lg_n[d] <= lg_n[d] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One stage request; cyc = cycles from presentation until ready (0 = same-cycle hit).
    task automatic req(input int d, input logic wen, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        s_valid[d] = 1'b1; s_wen[d] = wen; s_size[d] = sz; s_addr[d] = addr; s_wdata[d] = wd;
        cyc = 0;
        #1;
        while (!s_ready[d] && cyc < 40) begin
            @(negedge clk); #1; cyc++;
        end
        chk("req_timeout", {31'h0, s_ready[d]}, 32'd1);
        rd = s_rdata[d];
        @(negedge clk);
        s_valid[d] = 1'b0;
    endtask

    task automatic rd_chk(input int d, input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] exp_data, input int exp_cyc);
        logic [31:0] rd;
        int cyc;
        req(d, 1'b0, sz, addr, 32'h0, rd, cyc);
        chk({tag, "_data"}, rd, exp_data);
        chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int cyc, base;
        rst_n = 2'b00; flush = 2'b00; s_valid = 2'b00; s_wen = 2'b00;
        for (int d = 0; d < 2; d++) begin
            s_size[d] = SZ_W; s_addr[d] = '0; s_wdata[d] = '0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_stage_ready", {31'h0, s_ready[d]}, 32'd0);
            chk("rst_stage_rdata", s_rdata[d], 32'h0);
            chk("rst_axi_valid", {31'h0, a_valid[d]}, 32'd0);
            chk("rst_axi_addr", a_addr[d], 32'h0);
            chk("rst_axi_wen", {31'h0, a_wen[d]}, 32'd0);
            chk("rst_axi_size", {30'h0, a_size[d]}, {30'h0, SZ_W});
            chk("rst_axi_wdata", a_wdata[d], 32'h0);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 2'b11;
        @(negedge clk);

        // Cold read: two ascending beats, hit after TAG, then 0-cycle hits.
        base = lg_n[0];
        rd_chk(0, "cold_104", SZ_W, 32'h104, 32'h1234_0104, 5);
        chk("cold_beats", 32'(lg_n[0] - base), 32'd2);
        chk("cold_beat0_addr", lg_addr[0][base % 64], 32'h100);
        chk("cold_beat1_addr", lg_addr[0][(base + 1) % 64], 32'h104);
        chk("cold_beat_wen", {31'h0, lg_wen[0][base % 64]}, 32'd0);
        chk("cold_beat_size", {30'h0, lg_size[0][base % 64]}, {30'h0, SZ_W});
        rd_chk(0, "hit_104", SZ_W, 32'h104, 32'h1234_0104, 0);
        rd_chk(0, "hit_100", SZ_W, 32'h100, 32'hAABBCCDD, 0);

        // Same-set conflicts and round-robin eviction.
        rd_chk(0, "miss_200", SZ_W, 32'h200, 32'h1234_0200, 5);
        rd_chk(0, "miss_300", SZ_W, 32'h300, 32'h1234_0300, 5);
        rd_chk(0, "hit_200", SZ_W, 32'h200, 32'h1234_0200, 0);
        rd_chk(0, "evicted_100", SZ_W, 32'h100, 32'hAABBCCDD, 5);
        rd_chk(0, "hit_300", SZ_W, 32'h300, 32'h1234_0300, 0);

        // Sub-word reads.
        rd_chk(0, "byte_103", SZ_B, 32'h103, 32'h0000_00AA, 0);
        rd_chk(0, "half_102", SZ_H, 32'h102, 32'h0000_AABB, 0);
        rd_chk(0, "byte_101", SZ_B, 32'h101, 32'h0000_00CC, 0);

        // Store hit forwards to AXI and updates the line; store miss does not allocate.
        base = lg_n[0];
        req(0, 1'b1, SZ_B, 32'h101, 32'h0000_0055, rd, cyc);
        chk("st_cyc", 32'(cyc), 32'd1);
        chk("st_axi_count", 32'(lg_n[0] - base), 32'd1);
        chk("st_axi_addr", lg_addr[0][base % 64], 32'h101);
        chk("st_axi_wen", {31'h0, lg_wen[0][base % 64]}, 32'd1);
        chk("st_axi_size", {30'h0, lg_size[0][base % 64]}, {30'h0, SZ_B});
        chk("st_axi_wdata", lg_wdata[0][base % 64], 32'h0000_0055);
        rd_chk(0, "st_updated_100", SZ_W, 32'h100, 32'hAABB55DD, 0);
        base = lg_n[0];
        req(0, 1'b1, SZ_W, 32'h500, 32'hDEADBEEF, rd, cyc);
        chk("st_miss_axi_count", 32'(lg_n[0] - base), 32'd1);
        rd_chk(0, "st_miss_500", SZ_W, 32'h500, 32'h1234_0500, 5);

        // Flush during fill beat 0: both beats go out, line stays invalid, request refills.
        base = lg_n[0];
        s_valid[0] = 1'b1; s_wen[0] = 1'b0; s_size[0] = SZ_W; s_addr[0] = 32'h108;
        @(posedge clk); @(negedge clk);
        flush[0] = 1'b1;
        #1;
        chk("fl_axi_valid", {31'h0, a_valid[0]}, 32'd1);
        chk("fl_axi_addr", a_addr[0], 32'h108);
        @(negedge clk);
        flush[0] = 1'b0;
        cyc = 0;
        #1;
        while (!s_ready[0] && cyc < 60) begin
            @(negedge clk); #1; cyc++;
        end
        chk("fl_ready", {31'h0, s_ready[0]}, 32'd1);
        chk("fl_rdata", s_rdata[0], 32'h1234_0108);
        chk("fl_beats", 32'(lg_n[0] - base), 32'd4);
        chk("fl_beat1_addr", lg_addr[0][(base + 1) % 64], 32'h10C);
        @(negedge clk);
        s_valid[0] = 1'b0;
        rd_chk(0, "fl_hit_108", SZ_W, 32'h108, 32'h1234_0108, 0);
        rd_chk(0, "fl_cleared_100", SZ_W, 32'h100, 32'hAABBCCDD, 5);

        // Reset mid-fill drops axi valid at once and invalidates everything.
        s_valid[0] = 1'b1; s_addr[0] = 32'h300;
        @(posedge clk); @(negedge clk);
        #1;
        chk("rs_axi_valid_before", {31'h0, a_valid[0]}, 32'd1);
        rst_n[0] = 1'b0;
        #1;
        chk("rs_axi_valid_async", {31'h0, a_valid[0]}, 32'd0);
        s_valid[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        rd_chk(0, "rs_miss_108", SZ_W, 32'h108, 32'h1234_0108, 5);
        rd_chk(0, "rs_miss_100", SZ_W, 32'h100, 32'hAABBCCDD, 5);

        // Direct-mapped instance.
        rd_chk(1, "dm_cold_104", SZ_W, 32'h104, 32'h1234_0104, 5);
        rd_chk(1, "dm_hit_104", SZ_W, 32'h104, 32'h1234_0104, 0);
        rd_chk(1, "dm_hit_100", SZ_W, 32'h100, 32'hAABBCCDD, 0);
        rd_chk(1, "dm_miss_200", SZ_W, 32'h200, 32'h1234_0200, 5);
        rd_chk(1, "dm_evicted_100", SZ_W, 32'h100, 32'hAABBCCDD, 5);
        rd_chk(1, "dm_byte_103", SZ_B, 32'h103, 32'h0000_00AA, 0);
        rd_chk(1, "dm_half_102", SZ_H, 32'h102, 32'h0000_AABB, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
